// File: rtl/pic_pkg.sv
// Shared encodings for the cascade acknowledge logic: device role and
// acknowledge-sequence state.
package pic_pkg;
  localparam logic PIC_SLAVE  = 1'b0;
  localparam logic PIC_MASTER = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_e;

  // The final INTA pulse is the 2nd in 8086 mode and the 3rd in 8080 mode.
  function automatic logic is_last_pulse(input ack_state_e s, input logic m86);
    return m86 ? (s == ACK2) : (s == ACK3);
  endfunction
endpackage

// File: rtl/cascade_master_driver_inta_edge_detect.sv
// INTA edge strobes. A low inta_n held across reset release is not an edge:
// the first cycle after reset only loads the history register.
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic o_fall,
  output logic o_rise
);
  logic r_prev;
  logic r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= inta_n;
      r_armed <= 1'b1;
    end
  end

  assign o_fall = r_armed &  r_prev & ~inta_n;
  assign o_rise = r_armed & ~r_prev &  inta_n;
endmodule

// File: rtl/cascade_master_driver.sv
// Master-side cascade driver: tracks the INTA pulse train, drives the slave
// address on CAS and decides who owns the data bus in each pulse.
module cascade_master_driver
  import pic_pkg::*;
#(
  parameter logic SLAVE  = PIC_SLAVE,
  parameter logic MASTER = PIC_MASTER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sp_en,
  input  logic       sngl,
  input  logic [7:0] icw3_map,
  input  logic       mode_8086,
  input  logic       inta_n,
  input  logic       ack_valid,
  input  logic [2:0] ack_level,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       master_data_en,
  output logic       ack_done,
  output logic       ack_cascaded
);
  logic       w_fall, w_rise;
  logic [2:0] w_level;
  logic       w_casc;
  logic       w_is_master;

  ack_state_e r_state;
  logic       r_m86;
  logic       r_casc;
  logic       r_cas_oe;
  logic [2:0] r_cas_out;
  logic       r_mde;
  logic       r_done;

  inta_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  assign w_is_master = (sp_en == MASTER);
  // No winner at the first edge means a spurious IR7, never cascaded.
  assign w_level = ack_valid ? ack_level : 3'd7;
  assign w_casc  = w_is_master & ~sngl & ack_valid & icw3_map[w_level];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m86     <= 1'b0;
      r_casc    <= 1'b0;
      r_cas_oe  <= 1'b0;
      r_cas_out <= 3'd0;
      r_mde     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            r_state   <= ACK1;
            r_m86     <= mode_8086;
            r_casc    <= w_casc;
            r_cas_oe  <= w_casc;
            r_cas_out <= w_casc ? w_level : 3'd0;
            r_mde     <= ~mode_8086;
          end
          ACK1: begin
            r_state <= ACK2;
            r_mde   <= ~r_casc;
          end
          ACK2: begin
            if (!r_m86) begin
              r_state <= ACK3;
              r_mde   <= ~r_casc;
            end
          end
          default: ;
        endcase
      end else if (w_rise) begin
        r_mde <= 1'b0;
        if (is_last_pulse(r_state, r_m86)) begin
          r_state   <= IDLE;
          r_done    <= 1'b1;
          r_cas_oe  <= 1'b0;
          r_cas_out <= 3'd0;
        end
      end
    end
  end

  // A slave never drives CAS, even if the role input flips mid-sequence.
  assign cas_oe         = r_cas_oe & w_is_master;
  assign cas_out        = cas_oe ? r_cas_out : 3'd0;
  assign master_data_en = r_mde;
  assign ack_done       = r_done;
  assign ack_cascaded   = r_casc;
endmodule

// File: tb/tb_cascade_master_driver.sv
// Bench for cascade_master_driver: pulse-counting reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cascade_master_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sp_en = 1'b1;
  logic       sngl = 1'b0;
  logic [7:0] icw3_map = 8'h00;
  logic       mode_8086 = 1'b1;
  logic       inta_n = 1'b1;
  logic       ack_valid = 1'b1;
  logic [2:0] ack_level = 3'd0;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic       master_data_en;
  logic       ack_done;
  logic       ack_cascaded;

  int n_chk = 0;
  int n_err = 0;

  cascade_master_driver #(.SLAVE(1'b0), .MASTER(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sp_en          (sp_en),
    .sngl           (sngl),
    .icw3_map       (icw3_map),
    .mode_8086      (mode_8086),
    .inta_n         (inta_n),
    .ack_valid      (ack_valid),
    .ack_level      (ack_level),
    .cas_out        (cas_out),
    .cas_oe         (cas_oe),
    .master_data_en (master_data_en),
    .ack_done       (ack_done),
    .ack_cascaded   (ack_cascaded)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts INTA pulses of the current sequence (0 = none).
  int m_k = 0;
  int m_lvl = 0;
  bit m_prev = 1'b1, m_armed = 1'b0;
  bit m_casc = 1'b0, m_m86 = 1'b0, m_mde = 1'b0, m_done = 1'b0;

  task automatic m_reset();
    m_k = 0; m_lvl = 0; m_prev = 1'b1; m_armed = 1'b0;
    m_casc = 1'b0; m_m86 = 1'b0; m_mde = 1'b0; m_done = 1'b0;
  endtask

  task automatic m_step();
    bit fall, rise;
    fall = m_armed && m_prev && !inta_n;
    rise = m_armed && !m_prev && inta_n;
    m_done = 1'b0;
    if (fall) begin
      if (m_k == 0) begin
        m_lvl  = ack_valid ? int'(ack_level) : 7;
        m_casc = sp_en && !sngl && ack_valid && icw3_map[m_lvl];
        m_m86  = mode_8086;
        m_k    = 1;
      end else begin
        m_k++;
      end
      m_mde = (m_k == 1) ? !m_m86 : !m_casc;
    end else if (rise) begin
      m_mde = 1'b0;
      if (m_k == (m_m86 ? 2 : 3)) begin
        m_done = 1'b1;
        m_k    = 0;
      end
    end
    m_prev  = inta_n;
    m_armed = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    bit exp_oe;
    @(negedge clk);
    exp_oe = (m_k != 0) && m_casc && sp_en;
    chk("cas_oe",       int'(cas_oe),         int'(exp_oe));
    chk("cas_out",      int'(cas_out),        exp_oe ? m_lvl : 0);
    chk("data_en",      int'(master_data_en), int'(m_mde));
    chk("ack_done",     int'(ack_done),       int'(m_done));
    chk("ack_cascaded", int'(ack_cascaded),   int'(m_casc));
    if (!sp_en) chk("slave_quiet", int'({cas_oe, cas_out}), 0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    step(); step();
    at_neg();
    chk("rst_cas_oe", int'(cas_oe), 0);
    chk("rst_done",   int'(ack_done), 0);
    rst_n = 1'b1;
    step(); step();

    // Cascaded 8086 sequence to the slave on IR5.
    sp_en = 1'b1; sngl = 1'b0; mode_8086 = 1'b1; icw3_map = 8'h20;
    ack_valid = 1'b1; ack_level = 3'd5;
    inta_n = 1'b0; step(); at_neg();
    chk("c86_p1_cas_out", int'(cas_out), 5);
    chk("c86_p1_cas_oe",  int'(cas_oe), 1);
    chk("c86_p1_den",     int'(master_data_en), 0);
    step(); inta_n = 1'b1; step(); at_neg();
    chk("c86_gap_cas_oe", int'(cas_oe), 1);
    step(); inta_n = 1'b0; step(); at_neg();
    chk("c86_p2_den",     int'(master_data_en), 0);
    chk("c86_p2_cas_out", int'(cas_out), 5);
    step(); inta_n = 1'b1; step(); at_neg();
    chk("c86_done",       int'(ack_done), 1);
    chk("c86_done_oe",    int'(cas_oe), 0);
    step(); at_neg();
    chk("c86_done_pulse", int'(ack_done), 0);

    // Non-cascaded 8080 sequence: master owns the bus in every pulse.
    mode_8086 = 1'b0; icw3_map = 8'h00; ack_level = 3'd3;
    for (int p = 1; p <= 3; p++) begin
      inta_n = 1'b0; step(); at_neg();
      chk("n80_den", int'(master_data_en), 1);
      chk("n80_oe",  int'(cas_oe), 0);
      step(); inta_n = 1'b1; step(); at_neg();
      chk("n80_done", int'(ack_done), (p == 3) ? 1 : 0);
      step();
    end

    // No winner: forced level 7, never cascaded despite a full map.
    mode_8086 = 1'b1; icw3_map = 8'hFF; ack_valid = 1'b0; ack_level = 3'd2;
    inta_n = 1'b0; step(); at_neg();
    chk("nv_p1_den", int'(master_data_en), 0);
    chk("nv_casc",   int'(ack_cascaded), 0);
    step(); inta_n = 1'b1; step(); step();
    inta_n = 1'b0; step(); at_neg();
    chk("nv_p2_den", int'(master_data_en), 1);
    chk("nv_p2_oe",  int'(cas_oe), 0);
    step(); inta_n = 1'b1; step(); at_neg();
    chk("nv_done", int'(ack_done), 1);
    step();

    // Reset during ACK2 with CAS driven.
    ack_valid = 1'b1; icw3_map = 8'h20; ack_level = 3'd5;
    inta_n = 1'b0; step(); step(); inta_n = 1'b1; step();
    inta_n = 1'b0; step(); at_neg();
    chk("rs_pre_oe", int'(cas_oe), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_oe",   int'(cas_oe), 0);
    chk("rs_out",  int'(cas_out), 0);
    chk("rs_den",  int'(master_data_en), 0);
    chk("rs_casc", int'(ack_cascaded), 0);
    step(); rst_n = 1'b1; step(); step(); at_neg();
    chk("rs_low_no_edge", int'(cas_oe), 0);
    inta_n = 1'b1; step(); step();
    inta_n = 1'b0; step(); at_neg();
    chk("rs_new_ack1_out", int'(cas_out), 5);
    chk("rs_new_ack1_den", int'(master_data_en), 0);
    step(); inta_n = 1'b1; step(); inta_n = 1'b0; step();
    inta_n = 1'b1; step(); at_neg();
    chk("rs_new_done", int'(ack_done), 1);
    step();

    // Back-to-back: next falling edge lands in the ack_done cycle.
    icw3_map = 8'h24; ack_level = 3'd5;
    inta_n = 1'b0; step(); ack_level = 3'd2;
    at_neg();
    chk("bb1_latched", int'(cas_out), 5);
    step(); inta_n = 1'b1; step(); inta_n = 1'b0; step(); step();
    inta_n = 1'b1; step(); at_neg();
    chk("bb1_done", int'(ack_done), 1);
    inta_n = 1'b0; step(); at_neg();
    chk("bb2_out",  int'(cas_out), 2);
    chk("bb2_oe",   int'(cas_oe), 1);
    step(); inta_n = 1'b1; step(); inta_n = 1'b0; step(); step();
    inta_n = 1'b1; step(); at_neg();
    chk("bb2_done", int'(ack_done), 1);
    step(); step();

    // Randomized traffic, alternating master and slave phases.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      ack_valid = ($urandom_range(0, 3) != 0);
      ack_level = 3'($urandom);
      icw3_map  = 8'($urandom);
      mode_8086 = 1'($urandom);
      sngl      = ($urandom_range(0, 3) == 0);
      sp_en     = ((i / 500) % 2) == 0;
      rst_n     = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
